// File: rtl/cpu_mem_responder_if.sv
// Bus bundle between the CPU core (master) and its memory responder (slave):
// instruction fetch, data load/store handshake and the memory preload port.
interface cpu_mem_responder_if;
    logic [31:0] i_addr;
    logic [31:0] i_datain;
    logic [31:0] d_addr;
    logic [31:0] d_dataout;
    logic        d_re;
    logic        d_we;
    logic [31:0] d_datain;
    logic        d_ready;
    logic        d_err;
    logic        prog_we;
    logic        prog_sel;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;

    modport master (
        output i_addr, d_addr, d_dataout, d_re, d_we,
               prog_we, prog_sel, prog_addr, prog_wdata,
        input  i_datain, d_datain, d_ready, d_err
    );

    modport slave (
        input  i_addr, d_addr, d_dataout, d_re, d_we,
               prog_we, prog_sel, prog_addr, prog_wdata,
        output i_datain, d_datain, d_ready, d_err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: registered instruction fetch plus a wait-stated
// load/store port, with a preload path into both memories.
module cpu_mem_responder #(
    parameter int IMEM_AW  = 8,
    parameter int DMEM_AW  = 8,
    parameter int DATA_LAT = 2
) (
    input  logic               clock,
    input  logic               start,
    cpu_mem_responder_if.slave bus
);
    localparam logic [3:0] LAT = 4'(DATA_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] imem [2**IMEM_AW];
    logic [31:0] dmem [2**DMEM_AW];

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        store_reg, store_next;
    logic        both_reg, both_next;

    logic [31:0] i_datain_reg;
    logic [31:0] d_datain_reg;
    logic        d_ready_reg;
    logic        d_err_reg;

    logic               fetch_ok;
    logic [IMEM_AW-1:0] fetch_idx;
    logic               acc_oob;
    logic [DMEM_AW-1:0] acc_idx;
    logic               resp;
    logic               store_fire;
    logic               prog_imem_we;
    logic               prog_dmem_we;

    assign fetch_idx = bus.i_addr[IMEM_AW+1:2];
    assign fetch_ok  = (bus.i_addr[31:IMEM_AW+2] == '0) && (bus.i_addr[1:0] == 2'b00);

    assign acc_idx    = addr_reg[DMEM_AW-1:0];
    assign acc_oob    = (addr_reg[31:DMEM_AW] != '0);
    assign resp       = (state_reg == RESP);
    assign store_fire = resp && store_reg && !acc_oob;

    assign prog_imem_we = bus.prog_we && !bus.prog_sel && (bus.prog_addr[31:IMEM_AW] == '0);
    assign prog_dmem_we = bus.prog_we &&  bus.prog_sel && (bus.prog_addr[31:DMEM_AW] == '0);

    // Memories are never reset so preload contents survive (and can be loaded during) reset.
    always_ff @(posedge clock) begin
        if (prog_imem_we) begin
            imem[bus.prog_addr[IMEM_AW-1:0]] <= bus.prog_wdata;
        end
    end

    // Preload is written last so it overrides a CPU store to the same word in the same cycle.
    always_ff @(posedge clock) begin
        if (store_fire) begin
            dmem[acc_idx] <= wdata_reg;
        end
        if (prog_dmem_we) begin
            dmem[bus.prog_addr[DMEM_AW-1:0]] <= bus.prog_wdata;
        end
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            i_datain_reg <= '0;
            d_datain_reg <= '0;
            d_ready_reg  <= 1'b0;
            d_err_reg    <= 1'b0;
        end else begin
            i_datain_reg <= fetch_ok ? imem[fetch_idx] : 32'h0;
            d_ready_reg  <= resp;
            d_err_reg    <= resp && (acc_oob || both_reg);
            if (resp && !store_reg) begin
                d_datain_reg <= acc_oob ? 32'h0 : dmem[acc_idx];
            end
        end
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            store_reg <= 1'b0;
            both_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            store_reg <= store_next;
            both_reg  <= both_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        store_next = store_reg;
        both_next  = both_reg;
        case (state_reg)
            IDLE: begin
                if (bus.d_re || bus.d_we) begin
                    addr_next  = bus.d_addr;
                    wdata_next = bus.d_dataout;
                    store_next = bus.d_we;
                    both_next  = bus.d_re && bus.d_we;
                    cnt_next   = LAT;
                    state_next = (LAT != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.i_datain = i_datain_reg;
    assign bus.d_datain = d_datain_reg;
    assign bus.d_ready  = d_ready_reg;
    assign bus.d_err    = d_err_reg;
endmodule
